// File: rtl/lab5_g41_alu_issue_unit.sv
// Issue/capture stage around the combinational ALU: registers a/b/op, captures s and {n,z,v,c,hata}.
// Latency: accept edge, then one EXEC cycle; the result is captured at the next edge. Throughput is 1 result per 2 cycles.
// Backpressure: the result is held in HOLD until out_ready. in_ready=out_ready in HOLD. Optional feature macro: ACC_CHAIN_EN.
`timescale 1ns/1ps

module lab5_g41_alu_issue_unit #(
  parameter int WIDTH    = 32,
  parameter int OPW      = 4,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_a,
  input  logic [WIDTH-1:0]    in_b,
  input  logic [OPW-1:0]      in_op,
`ifdef ACC_CHAIN_EN
  input  logic                use_acc,
`endif
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  output logic [OPW-1:0]      alu_op,
  input  logic [WIDTH-1:0]    alu_s,
  input  logic [4:0]          alu_flags,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_s,
  output logic [4:0]          out_flags,
  output logic [ERRCNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic             accept;
  logic             capture;
  logic [WIDTH-1:0] a_sel;

  // Requests move when the upstream handshake completes; the ALU result is
  // taken exactly once, at the end of the single EXEC cycle.
  assign accept  = in_valid & in_ready;
  assign capture = (state == EXEC);

`ifdef ACC_CHAIN_EN
  // Chained requests reuse the currently held result as operand a. On a
  // HOLD-accept this is still the value being handed downstream, because a
  // new capture cannot happen in the same cycle as an accept.
  assign a_sel = use_acc ? out_s : in_a;
`else
  assign a_sel = in_a;
`endif

  // State register; reset drops any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode; out_valid is a pure state decode.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        // A consumed result frees the stage in the same cycle, so a queued
        // request can be taken without a bubble through IDLE.
        in_ready  = out_ready;
        if (out_ready) begin
          state_nxt = in_valid ? EXEC : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ALU operand registers keep the last accepted request in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
    end else if (accept) begin
      alu_a  <= a_sel;
      alu_b  <= in_b;
      alu_op <= in_op;
    end
  end

  // Result registers change only on a capture, so they stay stable in HOLD
  // and keep the last result after it has been consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_s     <= '0;
      out_flags <= '0;
    end else if (capture) begin
      out_s     <= alu_s;
      out_flags <= alu_flags;
    end
  end

  // Saturating count of captured results that carry hata (flags bit 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (capture && alu_flags[0] && (err_cnt != {ERRCNT_W{1'b1}})) begin
      err_cnt <= err_cnt + ERRCNT_W'(1);
    end
  end

  // An EXEC cycle always ends in a capture.
  a_exec_to_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (state == EXEC) |=> (state == HOLD));

  // An unconsumed result stays valid and unchanged.
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_s) && $stable(out_flags)));

endmodule

// File: tb/tb_lab5_g41_alu_issue_unit.sv
// Bench for lab5_g41_alu_issue_unit: two instances (8-bit and 2-bit error counters) share stimulus.
// A transaction-level model predicts every output each cycle; directed cases pin known results.
// Randomized valid/ready traffic, including long stalls and a mid-operation reset.
`timescale 1ns/1ps

module tb_lab5_g41_alu_issue_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_op;
`ifdef ACC_CHAIN_EN
  logic        use_acc;
`endif

  logic        d_in_ready, d_out_valid;
  logic [31:0] d_alu_a, d_alu_b, d_alu_s, d_out_s;
  logic [3:0]  d_alu_op;
  logic [4:0]  d_alu_flags, d_out_flags;
  logic [7:0]  d_err;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_alu_a, s_alu_b, s_alu_s, s_out_s;
  logic [3:0]  s_alu_op;
  logic [4:0]  s_alu_flags, s_out_flags;
  logic [1:0]  s_err;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  // Reference ALU: returns {s, n, z, v, c, hata}. c on subtract means "no borrow".
  function automatic logic [36:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    logic [32:0] t;
    logic [31:0] s;
    logic        v, c, h;
    t = '0; s = '0; v = 1'b0; c = 1'b0; h = 1'b0;
    case (op)
      4'b0000: begin
        t = {1'b0, a} + {1'b0, b};
        s = t[31:0]; c = t[32];
        v = (a[31] == b[31]) && (s[31] != a[31]);
      end
      4'b1000: begin
        t = {1'b0, a} - {1'b0, b};
        s = t[31:0]; c = ~t[32];
        v = (a[31] != b[31]) && (s[31] != a[31]);
      end
      4'b0001: s = a & b;
      4'b0010: s = a | b;
      4'b0011: s = a ^ b;
      default: h = 1'b1;
    endcase
    return {s, s[31], (s == 32'd0), v, c, h};
  endfunction

  assign {d_alu_s, d_alu_flags} = alu_f(d_alu_a, d_alu_b, d_alu_op);
  assign {s_alu_s, s_alu_flags} = alu_f(s_alu_a, s_alu_b, s_alu_op);

  lab5_g41_alu_issue_unit u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
`ifdef ACC_CHAIN_EN
    .use_acc(use_acc),
`endif
    .alu_a(d_alu_a), .alu_b(d_alu_b), .alu_op(d_alu_op),
    .alu_s(d_alu_s), .alu_flags(d_alu_flags),
    .out_valid(d_out_valid), .out_ready(out_ready),
    .out_s(d_out_s), .out_flags(d_out_flags), .err_cnt(d_err)
  );

  lab5_g41_alu_issue_unit #(.ERRCNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
`ifdef ACC_CHAIN_EN
    .use_acc(use_acc),
`endif
    .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_op(s_alu_op),
    .alu_s(s_alu_s), .alu_flags(s_alu_flags),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_s(s_out_s), .out_flags(s_out_flags), .err_cnt(s_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: a request "in flight" becomes a visible result
  // one edge later; the stage takes a new request only when nothing is in
  // flight and any visible result is either absent or being consumed.
  logic        m_pending, m_out_valid, m_last_fire;
  logic [31:0] m_a, m_b, m_out_s;
  logic [3:0]  m_op;
  logic [4:0]  m_flags;
  int          m_err;
  logic        m_rdy, m_fire;
  logic [36:0] mr;
  logic [31:0] m_next_a;

  assign m_rdy = !m_pending && (!m_out_valid || out_ready);
  assign m_fire = in_valid && m_rdy;
  assign mr = alu_f(m_a, m_b, m_op);
`ifdef ACC_CHAIN_EN
  assign m_next_a = use_acc ? m_out_s : in_a;
`else
  assign m_next_a = in_a;
`endif

  // Model update.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending <= 1'b0; m_out_valid <= 1'b0; m_last_fire <= 1'b0;
      m_a <= '0; m_b <= '0; m_op <= '0; m_out_s <= '0; m_flags <= '0; m_err <= 0;
    end else begin
      if (m_pending) begin
        m_out_s <= mr[36:5];
        m_flags <= mr[4:0];
        m_out_valid <= 1'b1;
        m_err <= m_err + int'(mr[0]);
        m_pending <= 1'b0;
      end else if (m_out_valid && out_ready) begin
        m_out_valid <= 1'b0;
      end
      if (m_fire) begin
        m_a <= m_next_a; m_b <= in_b; m_op <= in_op;
        m_pending <= 1'b1;
      end
      m_last_fire <= m_fire;
    end
  end

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready",  d_in_ready,  m_rdy);
      chk("out_valid", d_out_valid, m_out_valid);
      chk("alu_a",     d_alu_a,     m_a);
      chk("alu_b",     d_alu_b,     m_b);
      chk("alu_op",    d_alu_op,    m_op);
      chk("out_s",     d_out_s,     m_out_s);
      chk("out_flags", d_out_flags, m_flags);
      chk("err_cnt",   d_err,       (m_err > 255) ? 64'd255 : 64'(m_err));
      chk("sat_in_ready",  s_in_ready,  m_rdy);
      chk("sat_out_valid", s_out_valid, m_out_valid);
      chk("sat_out_s",     s_out_s,     m_out_s);
      chk("sat_err_cnt",   s_err,       (m_err > 3) ? 64'd3 : 64'(m_err));
    end
  end

  // Present a request and wait (bounded) for the accept edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    bit fired;
    fired = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
    for (int i = 0; i < 20 && !fired; i++) begin
      @(posedge clk); #1;
      fired = m_last_fire;
    end
    if (!fired) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  // The result is visible after the edge following the accept edge.
  task automatic expect_res(input string nm, input logic [31:0] s, input logic [2:0] nzh);
    @(posedge clk); #1;
    chk({nm, "_valid"}, d_out_valid, 1);
    chk({nm, "_s"}, d_out_s, s);
    chk({nm, "_nzh"}, {d_out_flags[4], d_out_flags[3], d_out_flags[0]}, nzh);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = '0;
`ifdef ACC_CHAIN_EN
    use_acc = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", d_in_ready, 1);
    chk("rst_out_valid", d_out_valid, 0);
    chk("rst_err", d_err, 0);
    chk("rst_alu_a", d_alu_a, 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Basic add, subtract with negative and zero results.
    out_ready = 1'b1;
    send(32'd41, 32'd34, 4'b0000);
    chk("add_alu_a", d_alu_a, 32'd41);
    chk("add_exec_valid", d_out_valid, 0);
    expect_res("add", 32'd75, 3'b000);
    send(32'd34, 32'd41, 4'b1000);
    expect_res("sub_neg", 32'hFFFF_FFF9, 3'b100);
    send(32'd41, 32'd41, 4'b1000);
    expect_res("sub_zero", 32'd0, 3'b010);

    // Invalid opcode: error counting and 2-bit saturation.
    for (int i = 0; i < 3; i++) begin
      send(32'd5, 32'd6, 4'b1111);
      expect_res("invalid", 32'd0, 3'b011);
    end
    chk("err3", d_err, 3);
    chk("sat_err3", s_err, 3);
    for (int i = 0; i < 2; i++) begin
      send(32'd5, 32'd6, 4'b1111);
      expect_res("invalid2", 32'd0, 3'b011);
    end
    chk("err5", d_err, 5);
    chk("sat_err5", s_err, 3);

    // Backpressure: result held while a queued request waits.
    send(32'd7, 32'd8, 4'b0000);
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 32'd100; in_b = 32'd5; in_op = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", d_in_ready, 0);
      chk("bp_out_s", d_out_s, 32'd15);
      chk("bp_out_valid", d_out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", d_in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_alu_a", d_alu_a, 32'd100);
    chk("bp_valid_drop", d_out_valid, 0);
    expect_res("bp_res", 32'd105, 3'b000);

`ifdef ACC_CHAIN_EN
    send(32'd41, 32'd34, 4'b0000);
    expect_res("acc_base", 32'd75, 3'b000);
    use_acc = 1'b1;
    send(32'd999, 32'd25, 4'b0000);
    use_acc = 1'b0;
    expect_res("acc_chain", 32'd100, 3'b000);
`endif

    // Randomized traffic; a request stays put until it is accepted.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      if (!in_valid || m_last_fire) begin
        int sel;
        in_valid = ($urandom_range(0, 3) != 0);
        in_a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom();
        in_b = ($urandom_range(0, 4) == 0) ? in_a : $urandom();
        sel = $urandom_range(0, 9);
        case (sel)
          0, 1:    in_op = 4'b0000;
          2, 3:    in_op = 4'b1000;
          4:       in_op = 4'b0001;
          5:       in_op = 4'b0010;
          6:       in_op = 4'b0011;
          7, 8:    in_op = 4'b1111;
          default: in_op = 4'($urandom_range(4, 7));
        endcase
`ifdef ACC_CHAIN_EN
        use_acc = ($urandom_range(0, 2) == 0);
`endif
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end

    // Reset in the middle of an operation.
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 32'd9; in_b = 32'd9; in_op = 4'b1111;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #2;
    chk("mid_rst_out_valid", d_out_valid, 0);
    chk("mid_rst_in_ready", d_in_ready, 1);
    chk("mid_rst_err", d_err, 0);
    chk("mid_rst_alu_a", d_alu_a, 0);
    chk("mid_rst_out_s", d_out_s, 0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(32'd41, 32'd34, 4'b0000);
    expect_res("post_rst", 32'd75, 3'b000);
    chk("post_rst_err", d_err, 0);

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
